// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider: default counter width, divisor
// active out of reset, and the smallest divisor a load may carry.
// No logic; imported by the divider top.
package clk_div_pkg;

  localparam int CLK_DIV_WIDTH = 8;
  localparam int CLK_DIV_RESET = 3;
  localparam int CLK_DIV_MIN   = 2;

endpackage

// File: rtl/clk_div_n_negff.sv
// Negedge retiming flop for the divided clock; kept on its own so it can be
// constrained separately. Latency: half an input clock period.
// No backpressure; asynchronous active-low clear.
module clk_div_n_negff (
  input  logic d,
  output logic q,
  input  logic clk,
  input  logic rst_n
);

  // Capture the posedge phase flop half a cycle later.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/clk_div_n.sv
// Divide clk_i by a runtime divisor D with 50% duty (half-cycle resolution for odd D).
// Latency: divisor loads take effect at the period boundary after capture; en_i acts at boundaries.
// No backpressure: loads are single-cycle strobes; last valid load wins. CLK_DIV_N_TICK_EN adds tick_o.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int WIDTH     = CLK_DIV_WIDTH,
  parameter int DIV_RESET = CLK_DIV_RESET
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_load_i,
  output logic             clk_o,
  output logic             div_busy_o,
  output logic             div_err_o
`ifdef CLK_DIV_N_TICK_EN
  ,
  output logic             tick_o
`endif
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(CLK_DIV_MIN);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DIV_RESET);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             err_q, err_d;
  logic             run_q, run_d;
  logic             pos_q, pos_d;
  logic             odd_q, odd_d;
  logic             shift_q, shift_d;
  logic             neg_q;

  logic [WIDTH:0]   half;
  logic [WIDTH-1:0] div_next;
  logic             at_end, boundary, load_ok, start, period_odd;

  // Period counter, run/idle control, divisor staging and output-shape select.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = err_q;
    run_d      = run_q;
    pos_d      = pos_q;
    odd_d      = odd_q;
    shift_d    = shift_q;

    half       = ({1'b0, div_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    at_end     = run_q && (cnt_q == div_q - ONE);
    boundary   = at_end || !run_q;
    load_ok    = div_load_i && (div_i >= MIN_DIV);
    div_next   = pend_vld_q ? pend_q : div_q;
    // Posedge on which pos_q rises: cnt 0 while running, or an enabled idle edge.
    start      = run_q ? (cnt_q == '0) : en_i;
    period_odd = boundary ? div_next[0] : div_q[0];

    if (run_q) begin
      pos_d = ({1'b0, cnt_q} < half);
      cnt_d = at_end ? '0 : cnt_q + ONE;
      run_d = !at_end || en_i;
    end else begin
      // An enabled idle edge is the cnt==0 edge of a fresh period.
      pos_d = en_i;
      cnt_d = en_i ? ONE : '0;
      run_d = en_i;
    end

    // Output shape changes only at a rising edge of pos_q, when pos_q and neg_q
    // are both low, so the select can never cut a phase short. After an odd
    // period an even divisor is taken from neg_q: its low phase then keeps the
    // odd half-cycle and every later phase stays exact.
    if (start) begin
      odd_d   = period_odd;
      shift_d = !period_odd && run_q && (odd_q || shift_q);
    end

    if (boundary) div_d = div_next;

    // A load coinciding with a boundary stays pending for the following one.
    if (load_ok) begin
      pend_d     = div_i;
      pend_vld_d = 1'b1;
      err_d      = 1'b0;
    end else begin
      if (div_load_i) err_d = 1'b1;
      if (boundary)   pend_vld_d = 1'b0;
    end
  end

  // Posedge state registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
      pos_q      <= 1'b0;
      odd_q      <= 1'b0;
      shift_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      run_q      <= run_d;
      pos_q      <= pos_d;
      odd_q      <= odd_d;
      shift_q    <= shift_d;
    end
  end

  clk_div_n_negff u_negff (
    .d     (pos_q),
    .q     (neg_q),
    .clk   (clk_i),
    .rst_n (rst_n)
  );

  assign clk_o      = odd_q ? (pos_q & neg_q) : (shift_q ? neg_q : pos_q);
  assign div_busy_o = pend_vld_q;
  assign div_err_o  = err_q;

`ifdef CLK_DIV_N_TICK_EN
  logic tick_q;

  // One-cycle pulse for the posedge on which pos_q rises.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= start;
  end

  assign tick_o = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// Directed bench for clk_div_n: clk_o sampled 1 time unit after every clk_i edge,
// compared against hand-derived half-cycle waveforms (oldest sample is the MSB).
// Scenarios run back to back on one continuous timeline.
module tb_clk_div_n;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_i = 1'b0;
  logic [7:0] div_i = 8'd0;
  logic       div_load_i = 1'b0;
  logic       clk_o;
  logic       div_busy_o;
  logic       div_err_o;
`ifdef CLK_DIV_N_TICK_EN
  logic        tick_o;
  logic [63:0] th;
`endif

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [63:0] cv;
  logic [63:0] bv;

  clk_div_n #(.WIDTH(8), .DIV_RESET(3)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .clk_o      (clk_o),
    .div_busy_o (div_busy_o),
    .div_err_o  (div_err_o)
`ifdef CLK_DIV_N_TICK_EN
    ,
    .tick_o     (tick_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Record n half-cycle samples of clk_o / div_busy_o (and tick_o).
  task automatic sample_halves(input int n);
    cv = '0;
    bv = '0;
`ifdef CLK_DIV_N_TICK_EN
    th = '0;
`endif
    for (int i = 0; i < n; i++) begin
      @(clk_i);
      #1;
      cv = {cv[62:0], clk_o};
      bv = {bv[62:0], div_busy_o};
`ifdef CLK_DIV_N_TICK_EN
      th = {th[62:0], tick_o};
`endif
    end
  endtask

  task automatic test_reset();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk_cnt++;
    if (clk_o !== 1'b0) $display("FAIL reset_clk_o: got %b expected 0", clk_o);
    else pass_cnt++;
    chk_cnt++;
    if (div_busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", div_busy_o);
    else pass_cnt++;
    chk_cnt++;
    if (div_err_o !== 1'b0) $display("FAIL reset_err: got %b expected 0", div_err_o);
    else pass_cnt++;
`ifdef CLK_DIV_N_TICK_EN
    chk_cnt++;
    if (tick_o !== 1'b0) $display("FAIL reset_tick: got %b expected 0", tick_o);
    else pass_cnt++;
`endif
  endtask

  // D=3 out of reset: 1.5 high / 1.5 low, period started on first posedge.
  task automatic test_default_div();
    en_i = 1'b1;
    @(negedge clk_i); #1;
    rst_n = 1'b1;
    sample_halves(12);
    chk_cnt++;
    if (cv !== 64'b011100011100) $display("FAIL default_div3_wave: got %b expected %b", cv[11:0], 12'b011100011100);
    else pass_cnt++;
`ifdef CLK_DIV_N_TICK_EN
    chk_cnt++;
    if (th !== 64'b110000110000) $display("FAIL default_tick: got %b expected %b", th[11:0], 12'b110000110000);
    else pass_cnt++;
`endif
  endtask

  // Load 4 mid-period of D=3: busy until boundary, then 2/2 with no short phase.
  task automatic test_load_div4();
    div_i = 8'd4;
    div_load_i = 1'b1;
    @(posedge clk_i); #1;
    div_load_i = 1'b0;
    chk_cnt++;
    if (div_busy_o !== 1'b1) $display("FAIL load4_busy_set: got %b expected 1", div_busy_o);
    else pass_cnt++;
    sample_halves(15);
    chk_cnt++;
    if (cv !== 64'b111000111100001) $display("FAIL load4_wave: got %b expected %b", cv[14:0], 15'b111000111100001);
    else pass_cnt++;
    chk_cnt++;
    if (bv !== 64'b111000000000000) $display("FAIL load4_busy_wave: got %b expected %b", bv[14:0], 15'b111000000000000);
    else pass_cnt++;
  endtask

  // Illegal divisor sets err and keeps D; a following load of 5 clears err.
  task automatic test_err_then_div5();
    div_i = 8'd1;
    div_load_i = 1'b1;
    @(posedge clk_i); #1;
    chk_cnt++;
    if (div_err_o !== 1'b1) $display("FAIL err_set: got %b expected 1", div_err_o);
    else pass_cnt++;
    chk_cnt++;
    if (div_busy_o !== 1'b0) $display("FAIL err_no_busy: got %b expected 0", div_busy_o);
    else pass_cnt++;
    div_i = 8'd5;
    @(posedge clk_i); #1;
    div_load_i = 1'b0;
    chk_cnt++;
    if (div_err_o !== 1'b0) $display("FAIL err_clear: got %b expected 0", div_err_o);
    else pass_cnt++;
    chk_cnt++;
    if (div_busy_o !== 1'b1) $display("FAIL div5_busy: got %b expected 1", div_busy_o);
    else pass_cnt++;
    sample_halves(15);
    chk_cnt++;
    if (cv !== 64'b000011111000001) $display("FAIL div5_wave: got %b expected %b", cv[14:0], 15'b000011111000001);
    else pass_cnt++;
    chk_cnt++;
    if (bv !== 64'b100000000000000) $display("FAIL div5_busy_wave: got %b expected %b", bv[14:0], 15'b100000000000000);
    else pass_cnt++;
  endtask

  // Loads 6 then 8 in one period: only 8 reaches the output.
  task automatic test_back_to_back();
    div_i = 8'd6;
    div_load_i = 1'b1;
    @(posedge clk_i); #1;
    div_i = 8'd8;
    @(posedge clk_i); #1;
    div_load_i = 1'b0;
    chk_cnt++;
    if (div_busy_o !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", div_busy_o);
    else pass_cnt++;
    sample_halves(23);
    chk_cnt++;
    if (cv !== 64'b10000011111111000000001) $display("FAIL b2b_div8_wave: got %b expected %b", cv[22:0], 23'b10000011111111000000001);
    else pass_cnt++;
    chk_cnt++;
    if (bv !== 64'b11100000000000000000000) $display("FAIL b2b_busy_wave: got %b expected %b", bv[22:0], 23'b11100000000000000000000);
    else pass_cnt++;
  endtask

  // Switch to D=6, drop en_i at cnt=1: period finishes, then low; restart on en_i.
  task automatic test_stop_restart();
    div_i = 8'd6;
    div_load_i = 1'b1;
    @(posedge clk_i); #1;
    div_load_i = 1'b0;
    chk_cnt++;
    if (div_busy_o !== 1'b1) $display("FAIL stop_load6_busy: got %b expected 1", div_busy_o);
    else pass_cnt++;
    repeat (7) @(posedge clk_i);
    #1;
    chk_cnt++;
    if (div_busy_o !== 1'b0) $display("FAIL stop_load6_applied: got %b expected 0", div_busy_o);
    else pass_cnt++;
    en_i = 1'b0;
    sample_halves(17);
    chk_cnt++;
    if (cv !== 64'b11111100000000000) $display("FAIL stop_wave: got %b expected %b", cv[16:0], 17'b11111100000000000);
    else pass_cnt++;
    en_i = 1'b1;
    @(posedge clk_i); #1;
    chk_cnt++;
    if (clk_o !== 1'b1) $display("FAIL restart_rise: got %b expected 1", clk_o);
    else pass_cnt++;
`ifdef CLK_DIV_N_TICK_EN
    chk_cnt++;
    if (tick_o !== 1'b1) $display("FAIL restart_tick: got %b expected 1", tick_o);
    else pass_cnt++;
`endif
    sample_halves(12);
    chk_cnt++;
    if (cv !== 64'b111110000001) $display("FAIL restart_div6_wave: got %b expected %b", cv[11:0], 12'b111110000001);
    else pass_cnt++;
  endtask

  // Reset while clk_o is high with a pending load and err set.
  task automatic test_reset_mid();
    div_i = 8'd4;
    div_load_i = 1'b1;
    @(posedge clk_i); #1;
    div_i = 8'd0;
    @(posedge clk_i); #1;
    div_load_i = 1'b0;
    chk_cnt++;
    if (div_err_o !== 1'b1) $display("FAIL bad_load_err: got %b expected 1", div_err_o);
    else pass_cnt++;
    chk_cnt++;
    if (div_busy_o !== 1'b1) $display("FAIL bad_load_keeps_pending: got %b expected 1", div_busy_o);
    else pass_cnt++;
    chk_cnt++;
    if (clk_o !== 1'b1) $display("FAIL pre_reset_high: got %b expected 1", clk_o);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (clk_o !== 1'b0) $display("FAIL async_reset_clk_o: got %b expected 0", clk_o);
    else pass_cnt++;
    chk_cnt++;
    if (div_busy_o !== 1'b0) $display("FAIL async_reset_busy: got %b expected 0", div_busy_o);
    else pass_cnt++;
    chk_cnt++;
    if (div_err_o !== 1'b0) $display("FAIL async_reset_err: got %b expected 0", div_err_o);
    else pass_cnt++;
`ifdef CLK_DIV_N_TICK_EN
    chk_cnt++;
    if (tick_o !== 1'b0) $display("FAIL async_reset_tick: got %b expected 0", tick_o);
    else pass_cnt++;
`endif
    @(negedge clk_i); #1;
    rst_n = 1'b1;
    sample_halves(6);
    chk_cnt++;
    if (cv !== 64'b011100) $display("FAIL post_reset_div3_wave: got %b expected %b", cv[5:0], 6'b011100);
    else pass_cnt++;
    chk_cnt++;
    if (div_busy_o !== 1'b0) $display("FAIL post_reset_no_pending: got %b expected 0", div_busy_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_load_div4();
    test_err_then_div5();
    test_back_to_back();
    test_stop_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
